// File: rtl/scalar_writeback_arbiter.sv
// scalar_writeback_arbiter
//
// Write-back stage feeding the single write port of the 16x32 scalar
// register bank. Load returns (never stalled) and ALU results (valid/ready)
// are merged into at most one registered write per cycle. ALU results that
// cannot be written right away wait in a 2-entry in-order FIFO. A 16-bit
// pending-load scoreboard is kept for the hazard logic, and a sticky flag
// records protocol violations.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   aluValid/aluAddr/aluData : ALU result offer; taken when aluValid && aluReady
//   aluReady        : FIFO has room (combinational from the count register)
//   memValid/memAddr/memData : load return, must be written this cycle
//   ldIssue/ldAddr  : load issued this cycle and its destination register
//   wEn_SR/regsAddr3/regsWriteData : registered register-bank write port
//   pendingMask     : registered scoreboard, bit i = load outstanding to ri
//   idle            : FIFO empty and no loads outstanding
//   protoErr        : sticky protocol-error flag, cleared only by rst

module scalar_writeback_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        aluValid,
    input  logic [3:0]  aluAddr,
    input  logic [31:0] aluData,
    output logic        aluReady,
    input  logic        memValid,
    input  logic [3:0]  memAddr,
    input  logic [31:0] memData,
    input  logic        ldIssue,
    input  logic [3:0]  ldAddr,
    output logic        wEn_SR,
    output logic [3:0]  regsAddr3,
    output logic [31:0] regsWriteData,
    output logic [15:0] pendingMask,
    output logic        idle,
    output logic        protoErr
);

    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    // Registered state
    logic [1:0]  count_r;
    logic [3:0]  fifo_addr_r [2];
    logic [31:0] fifo_data_r [2];
    logic [15:0] pend_r;
    logic        proto_err_r;
    logic        wen_r;
    logic [3:0]  waddr_r;
    logic [31:0] wdata_r;

    // Combinational decisions
    logic        alu_ready_s;
    logic        accept_s;
    logic        sel_valid_s;
    logic [3:0]  sel_addr_s;
    logic [31:0] sel_data_s;
    logic        push_s;
    logic        pop_s;
    logic [1:0]  wr_pos_s;
    logic [1:0]  count_next_s;
    logic [3:0]  fifo_addr_next_s [2];
    logic [31:0] fifo_data_next_s [2];
    logic [15:0] pend_next_s;
    logic        err_ld_s;
    logic        err_mem_s;
    logic        err_alu_s;

    assign alu_ready_s = !rst && (count_r < FULL_CNT);
    assign accept_s    = aluValid && alu_ready_s;

    // Write-source selection: load return, then FIFO head, then ALU bypass
    always_comb begin
        sel_valid_s = 1'b0;
        sel_addr_s  = 4'd0;
        sel_data_s  = 32'd0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        if (memValid) begin
            sel_valid_s = 1'b1;
            sel_addr_s  = memAddr;
            sel_data_s  = memData;
            push_s      = accept_s;
        end else if (count_r != 2'd0) begin
            sel_valid_s = 1'b1;
            sel_addr_s  = fifo_addr_r[0];
            sel_data_s  = fifo_data_r[0];
            pop_s       = 1'b1;
            push_s      = accept_s;
        end else if (accept_s) begin
            // Empty FIFO and no load return: the ALU result goes straight out
            sel_valid_s = 1'b1;
            sel_addr_s  = aluAddr;
            sel_data_s  = aluData;
        end else begin
            sel_valid_s = 1'b0;
        end
    end

    // FIFO next state: slot 0 is always the head, a pop shifts slot 1 down
    always_comb begin
        fifo_addr_next_s[0] = fifo_addr_r[0];
        fifo_addr_next_s[1] = fifo_addr_r[1];
        fifo_data_next_s[0] = fifo_data_r[0];
        fifo_data_next_s[1] = fifo_data_r[1];
        // A push lands behind whatever survives this cycle's pop
        wr_pos_s     = count_r - {1'b0, pop_s};
        count_next_s = count_r + {1'b0, push_s} - {1'b0, pop_s};
        if (pop_s) begin
            fifo_addr_next_s[0] = fifo_addr_r[1];
            fifo_data_next_s[0] = fifo_data_r[1];
        end else begin
            fifo_addr_next_s[0] = fifo_addr_r[0];
            fifo_data_next_s[0] = fifo_data_r[0];
        end
        if (push_s) begin
            case (wr_pos_s)
                2'd0: begin
                    fifo_addr_next_s[0] = aluAddr;
                    fifo_data_next_s[0] = aluData;
                end
                2'd1: begin
                    fifo_addr_next_s[1] = aluAddr;
                    fifo_data_next_s[1] = aluData;
                end
                default: begin
                    fifo_addr_next_s[1] = fifo_addr_r[1];
                end
            endcase
        end else begin
            fifo_addr_next_s[1] = fifo_addr_r[1];
        end
    end

    // Scoreboard update: clear on load return, then set on issue so set wins
    always_comb begin
        pend_next_s = pend_r;
        if (memValid) begin
            pend_next_s[memAddr] = 1'b0;
        end else begin
            pend_next_s = pend_r;
        end
        if (ldIssue) begin
            pend_next_s[ldAddr] = 1'b1;
        end else begin
            pend_next_s[15:0] = pend_next_s[15:0];
        end
    end

    // Protocol checks against the scoreboard as it stood at the start of the cycle
    assign err_ld_s  = ldIssue && pend_r[ldAddr] && !(memValid && (memAddr == ldAddr));
    assign err_mem_s = memValid && !pend_r[memAddr];
    assign err_alu_s = accept_s && pend_r[aluAddr];

    // State and registered write-port update
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r        <= 2'd0;
            fifo_addr_r[0] <= 4'd0;
            fifo_addr_r[1] <= 4'd0;
            fifo_data_r[0] <= 32'd0;
            fifo_data_r[1] <= 32'd0;
            pend_r         <= 16'd0;
            proto_err_r    <= 1'b0;
            wen_r          <= 1'b0;
            waddr_r        <= 4'd0;
            wdata_r        <= 32'd0;
        end else begin
            count_r        <= count_next_s;
            fifo_addr_r[0] <= fifo_addr_next_s[0];
            fifo_addr_r[1] <= fifo_addr_next_s[1];
            fifo_data_r[0] <= fifo_data_next_s[0];
            fifo_data_r[1] <= fifo_data_next_s[1];
            pend_r         <= pend_next_s;
            proto_err_r    <= proto_err_r | err_ld_s | err_mem_s | err_alu_s;
            wen_r          <= sel_valid_s;
            // Address and data hold their last value when nothing is written
            if (sel_valid_s) begin
                waddr_r <= sel_addr_s;
                wdata_r <= sel_data_s;
            end else begin
                waddr_r <= waddr_r;
                wdata_r <= wdata_r;
            end
        end
    end

    assign aluReady      = alu_ready_s;
    assign wEn_SR        = wen_r;
    assign regsAddr3     = waddr_r;
    assign regsWriteData = wdata_r;
    assign pendingMask   = pend_r;
    assign protoErr      = proto_err_r;
    assign idle          = (count_r == 2'd0) && (pend_r == 16'd0);

endmodule

// File: tb/tb_scalar_writeback_arbiter.sv
module tb_scalar_writeback_arbiter;

    logic        clk;
    logic        rst;
    logic        aluValid;
    logic [3:0]  aluAddr;
    logic [31:0] aluData;
    logic        aluReady;
    logic        memValid;
    logic [3:0]  memAddr;
    logic [31:0] memData;
    logic        ldIssue;
    logic [3:0]  ldAddr;
    logic        wEn_SR;
    logic [3:0]  regsAddr3;
    logic [31:0] regsWriteData;
    logic [15:0] pendingMask;
    logic        idle;
    logic        protoErr;

    int n_cmp;
    int n_bad;

    // Reference model state: ALU results waiting, outstanding loads, error flag
    logic [3:0]  q_addr [$];
    logic [31:0] q_data [$];
    logic [15:0] m_pend;
    logic        m_err;
    logic        m_wen;
    logic [3:0]  m_addr;
    logic [31:0] m_data;

    scalar_writeback_arbiter #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .aluValid(aluValid), .aluAddr(aluAddr), .aluData(aluData), .aluReady(aluReady),
        .memValid(memValid), .memAddr(memAddr), .memData(memData),
        .ldIssue(ldIssue), .ldAddr(ldAddr),
        .wEn_SR(wEn_SR), .regsAddr3(regsAddr3), .regsWriteData(regsWriteData),
        .pendingMask(pendingMask), .idle(idle), .protoErr(protoErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        aluValid = 1'b0; aluAddr = 4'd0; aluData = 32'd0;
        memValid = 1'b0; memAddr = 4'd0; memData = 32'd0;
        ldIssue  = 1'b0; ldAddr  = 4'd0;
    endtask

    // Advance the model by one cycle with the currently driven inputs, then clock the DUT.
    // Accepted ALU results join the back of the queue; the write is the load return if
    // any, otherwise the oldest queued ALU result (an empty queue makes that a bypass).
    task automatic tick();
        logic acc;
        if (rst) begin
            q_addr.delete(); q_data.delete();
            m_pend = 16'd0; m_err = 1'b0;
            m_wen = 1'b0; m_addr = 4'd0; m_data = 32'd0;
        end else begin
            acc = aluValid && (q_addr.size() < 2);
            if (ldIssue && m_pend[ldAddr] && !(memValid && memAddr == ldAddr)) m_err = 1'b1;
            if (memValid && !m_pend[memAddr]) m_err = 1'b1;
            if (acc && m_pend[aluAddr]) m_err = 1'b1;
            if (acc) begin
                q_addr.push_back(aluAddr);
                q_data.push_back(aluData);
            end
            if (memValid) begin
                m_wen = 1'b1; m_addr = memAddr; m_data = memData;
            end else if (q_addr.size() > 0) begin
                m_wen = 1'b1; m_addr = q_addr.pop_front(); m_data = q_data.pop_front();
            end else begin
                m_wen = 1'b0;
            end
            if (memValid) m_pend[memAddr] = 1'b0;
            if (ldIssue) m_pend[ldAddr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #1;
        n_cmp++; if (aluReady !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", aluReady); end
        tick();
        tick();
        n_cmp++; if (wEn_SR !== 1'b0) begin n_bad++; $display("FAIL reset_wen got %b want 0", wEn_SR); end
        n_cmp++; if (regsAddr3 !== 4'd0 || regsWriteData !== 32'd0) begin n_bad++;
            $display("FAIL reset_addr_data got %0d/%h want 0/0", regsAddr3, regsWriteData); end
        n_cmp++; if (pendingMask !== 16'd0 || protoErr !== 1'b0 || idle !== 1'b1) begin n_bad++;
            $display("FAIL reset_state got mask=%h err=%b idle=%b want 0/0/1", pendingMask, protoErr, idle); end
        rst = 1'b0;
        #1;
        n_cmp++; if (aluReady !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready got %b want 1", aluReady); end
    endtask

    task automatic test_bypass();
        aluValid = 1'b1; aluAddr = 4'd5; aluData = 32'h1234_5678;
        tick();
        clear_inputs();
        n_cmp++; if (wEn_SR !== 1'b1 || regsAddr3 !== 4'd5 || regsWriteData !== 32'h1234_5678) begin n_bad++;
            $display("FAIL bypass_write got %b/%0d/%h want 1/5/12345678", wEn_SR, regsAddr3, regsWriteData); end
        n_cmp++; if (aluReady !== 1'b1 || idle !== 1'b1) begin n_bad++;
            $display("FAIL bypass_count got ready=%b idle=%b want 1/1", aluReady, idle); end
        tick();
        n_cmp++; if (wEn_SR !== 1'b0 || regsAddr3 !== 4'd5) begin n_bad++;
            $display("FAIL bypass_hold got %b/%0d want 0/5", wEn_SR, regsAddr3); end
    endtask

    task automatic test_collision();
        ldIssue = 1'b1; ldAddr = 4'd3;
        tick();
        clear_inputs();
        memValid = 1'b1; memAddr = 4'd3; memData = 32'hAAAA_0000;
        aluValid = 1'b1; aluAddr = 4'd7; aluData = 32'h0000_BBBB;
        tick();
        clear_inputs();
        n_cmp++; if (wEn_SR !== 1'b1 || regsAddr3 !== 4'd3 || regsWriteData !== 32'hAAAA_0000) begin n_bad++;
            $display("FAIL collision_mem got %b/%0d/%h want 1/3/aaaa0000", wEn_SR, regsAddr3, regsWriteData); end
        n_cmp++; if (pendingMask !== 16'd0 || idle !== 1'b0) begin n_bad++;
            $display("FAIL collision_state got mask=%h idle=%b want 0/0", pendingMask, idle); end
        tick();
        n_cmp++; if (wEn_SR !== 1'b1 || regsAddr3 !== 4'd7 || regsWriteData !== 32'h0000_BBBB) begin n_bad++;
            $display("FAIL collision_alu got %b/%0d/%h want 1/7/0000bbbb", wEn_SR, regsAddr3, regsWriteData); end
        tick();
        n_cmp++; if (wEn_SR !== 1'b0 || idle !== 1'b1 || protoErr !== 1'b0) begin n_bad++;
            $display("FAIL collision_end got wen=%b idle=%b err=%b want 0/1/0", wEn_SR, idle, protoErr); end
    endtask

    task automatic test_backpressure();
        logic [3:0] next_alu;
        for (int i = 0; i < 3; i++) begin
            ldIssue = 1'b1; ldAddr = 4'(10 + i);
            tick();
        end
        clear_inputs();
        next_alu = 4'd1;
        for (int i = 0; i < 3; i++) begin
            memValid = 1'b1; memAddr = 4'(10 + i); memData = 32'hD000_0000 + 32'(i);
            aluValid = 1'b1; aluAddr = next_alu; aluData = 32'hA000_0000 + 32'(next_alu);
            #1;
            n_cmp++; if (aluReady !== (i < 2)) begin n_bad++;
                $display("FAIL backpressure_ready%0d got %b want %b", i, aluReady, (i < 2)); end
            if (aluReady) next_alu = next_alu + 4'd1;
            tick();
            n_cmp++; if (wEn_SR !== 1'b1 || regsAddr3 !== 4'(10 + i)) begin n_bad++;
                $display("FAIL backpressure_mem%0d got %b/%0d want 1/%0d", i, wEn_SR, regsAddr3, 10 + i); end
        end
        clear_inputs();
        tick();
        n_cmp++; if (regsAddr3 !== 4'd1 || regsWriteData !== 32'hA000_0001 || aluReady !== 1'b1) begin n_bad++;
            $display("FAIL backpressure_drain1 got %0d/%h ready=%b want 1/a0000001/1", regsAddr3, regsWriteData, aluReady); end
        tick();
        n_cmp++; if (wEn_SR !== 1'b1 || regsAddr3 !== 4'd2 || regsWriteData !== 32'hA000_0002) begin n_bad++;
            $display("FAIL backpressure_drain2 got %b/%0d/%h want 1/2/a0000002", wEn_SR, regsAddr3, regsWriteData); end
        tick();
        n_cmp++; if (wEn_SR !== 1'b0 || idle !== 1'b1 || aluReady !== 1'b1) begin n_bad++;
            $display("FAIL backpressure_end got wen=%b idle=%b ready=%b want 0/1/1", wEn_SR, idle, aluReady); end
    endtask

    task automatic test_scoreboard_race();
        ldIssue = 1'b1; ldAddr = 4'd9;
        tick();
        memValid = 1'b1; memAddr = 4'd9; memData = 32'h0000_0999;
        tick();
        clear_inputs();
        n_cmp++; if (pendingMask !== 16'h0200 || protoErr !== 1'b0) begin n_bad++;
            $display("FAIL race_setwins got mask=%h err=%b want 0200/0", pendingMask, protoErr); end
        n_cmp++; if (wEn_SR !== 1'b1 || regsAddr3 !== 4'd9) begin n_bad++;
            $display("FAIL race_write got %b/%0d want 1/9", wEn_SR, regsAddr3); end
        memValid = 1'b1; memAddr = 4'd9; memData = 32'h0000_0998;
        tick();
        clear_inputs();
        n_cmp++; if (pendingMask !== 16'd0 || protoErr !== 1'b0) begin n_bad++;
            $display("FAIL race_clear got mask=%h err=%b want 0/0", pendingMask, protoErr); end
    endtask

    task automatic test_errors();
        memValid = 1'b1; memAddr = 4'd2; memData = 32'hE000_0002;
        tick();
        clear_inputs();
        n_cmp++; if (wEn_SR !== 1'b1 || regsAddr3 !== 4'd2 || protoErr !== 1'b1) begin n_bad++;
            $display("FAIL err_mem_unpending got %b/%0d err=%b want 1/2/1", wEn_SR, regsAddr3, protoErr); end
        tick();
        n_cmp++; if (protoErr !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", protoErr); end
        ldIssue = 1'b1; ldAddr = 4'd4;
        tick();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (protoErr !== 1'b0 || pendingMask !== 16'd0 || idle !== 1'b1 || wEn_SR !== 1'b0) begin n_bad++;
            $display("FAIL err_reset got err=%b mask=%h idle=%b wen=%b want 0/0/1/0", protoErr, pendingMask, idle, wEn_SR); end
    endtask

    task automatic test_reset_mid_fill();
        ldIssue = 1'b1; ldAddr = 4'd4;
        tick();
        ldAddr = 4'd5;
        tick();
        clear_inputs();
        memValid = 1'b1; memAddr = 4'd4; aluValid = 1'b1; aluAddr = 4'd13; aluData = 32'h0000_000D;
        tick();
        memAddr = 4'd5; aluAddr = 4'd14; aluData = 32'h0000_000E;
        tick();
        clear_inputs();
        n_cmp++; if (aluReady !== 1'b0) begin n_bad++; $display("FAIL midfill_full got %b want 0", aluReady); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (wEn_SR !== 1'b0 || aluReady !== 1'b1 || idle !== 1'b1) begin n_bad++;
            $display("FAIL midfill_reset got wen=%b ready=%b idle=%b want 0/1/1", wEn_SR, aluReady, idle); end
        tick();
        n_cmp++; if (wEn_SR !== 1'b0) begin n_bad++; $display("FAIL midfill_nowrite got %b want 0", wEn_SR); end
        aluValid = 1'b1; aluAddr = 4'd6; aluData = 32'h6666_0006;
        tick();
        clear_inputs();
        n_cmp++; if (wEn_SR !== 1'b1 || regsAddr3 !== 4'd6 || regsWriteData !== 32'h6666_0006) begin n_bad++;
            $display("FAIL midfill_bypass got %b/%0d/%h want 1/6/66660006", wEn_SR, regsAddr3, regsWriteData); end
        tick();
        n_cmp++; if (wEn_SR !== 1'b0) begin n_bad++; $display("FAIL midfill_stale got %b want 0", wEn_SR); end
    endtask

    task automatic test_random();
        int start;
        logic [3:0] cand;
        for (int cyc = 0; cyc < 600; cyc++) begin
            clear_inputs();
            rst = ((cyc % 150) == 149) || ($urandom_range(0, 99) == 0);
            aluValid = ($urandom_range(0, 1) == 1);
            aluAddr  = 4'($urandom_range(0, 15));
            aluData  = $urandom;
            if (m_pend != 16'd0 && $urandom_range(0, 2) == 0) begin
                start = $urandom_range(0, 15);
                for (int k = 0; k < 16; k++) begin
                    cand = 4'((start + k) % 16);
                    if (m_pend[cand] && !memValid) begin
                        memValid = 1'b1; memAddr = cand;
                    end
                end
            end else if ($urandom_range(0, 49) == 0) begin
                memValid = 1'b1; memAddr = 4'($urandom_range(0, 15));
            end
            memData = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                ldAddr = 4'($urandom_range(0, 15));
                ldIssue = !m_pend[ldAddr] || ($urandom_range(0, 4) == 0);
            end
            #1;
            n_cmp++; if (aluReady !== (!rst && q_addr.size() < 2)) begin n_bad++;
                $display("FAIL rand_ready c%0d got %b want %b", cyc, aluReady, (!rst && q_addr.size() < 2)); end
            tick();
            n_cmp++; if (wEn_SR !== m_wen || regsAddr3 !== m_addr || regsWriteData !== m_data) begin n_bad++;
                $display("FAIL rand_write c%0d got %b/%0d/%h want %b/%0d/%h", cyc, wEn_SR, regsAddr3, regsWriteData, m_wen, m_addr, m_data); end
            n_cmp++; if (pendingMask !== m_pend || protoErr !== m_err) begin n_bad++;
                $display("FAIL rand_sb c%0d got %h/%b want %h/%b", cyc, pendingMask, protoErr, m_pend, m_err); end
            n_cmp++; if (idle !== (q_addr.size() == 0 && m_pend == 16'd0)) begin n_bad++;
                $display("FAIL rand_idle c%0d got %b want %b", cyc, idle, (q_addr.size() == 0 && m_pend == 16'd0)); end
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_pend = 16'd0; m_err = 1'b0; m_wen = 1'b0; m_addr = 4'd0; m_data = 32'd0;
        test_reset();
        test_bypass();
        test_collision();
        test_backpressure();
        test_scoreboard_race();
        test_errors();
        test_reset_mid_fill();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
